// File: rtl/lives_manager.sv
// Player life sequencer for Defender: start, hits, respawn delay, invulnerability window,
// extra-life awards and game over. Frame-based timing runs off the one-cycle frame_tick.
module lives_manager #(
  parameter int START_LIVES    = 3,
  parameter int MAX_LIVES      = 8,
  parameter int RESPAWN_FRAMES = 60,
  parameter int INVULN_FRAMES  = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_game,
  input  logic       hit,
  input  logic       extra_life,
  output logic [7:0] lives,
  output logic       ship_visible,
  output logic       invulnerable,
  output logic       respawn,
  output logic       game_over,
  output logic [2:0] state
);

  localparam int MAX_FRAMES = (RESPAWN_FRAMES > INVULN_FRAMES) ? RESPAWN_FRAMES : INVULN_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  localparam logic [7:0]       START_L   = 8'(START_LIVES);
  localparam logic [7:0]       MAX_L     = 8'(MAX_LIVES);
  localparam logic [CNT_W-1:0] RESPAWN_C = CNT_W'(RESPAWN_FRAMES);
  localparam logic [CNT_W-1:0] INVULN_C  = CNT_W'(INVULN_FRAMES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAYING   = 3'd1,
    DYING     = 3'd2,
    INVULN    = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t           state_reg;
  logic [7:0]       lives_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ship_visible_reg;
  logic             invulnerable_reg;
  logic             respawn_reg;
  logic             game_over_reg;

  // Saturating award, shared by every state that accepts extra_life.
  logic [7:0] lives_inc;
  assign lives_inc = (lives_reg < MAX_L) ? lives_reg + 8'd1 : MAX_L;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      lives_reg        <= 8'd0;
      cnt_reg          <= '0;
      ship_visible_reg <= 1'b0;
      invulnerable_reg <= 1'b0;
      respawn_reg      <= 1'b0;
      game_over_reg    <= 1'b0;
    end else begin
      respawn_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_game) begin
            state_reg        <= PLAYING;
            lives_reg        <= START_L;
            ship_visible_reg <= 1'b1;
          end
        end
        PLAYING: begin
          if (hit) begin
            if (extra_life || lives_reg > 8'd1) begin
              // A simultaneous award cancels the loss, except at the ceiling where it was already capped.
              if (!extra_life)
                lives_reg <= lives_reg - 8'd1;
              else if (lives_reg == MAX_L)
                lives_reg <= MAX_L - 8'd1;
              state_reg        <= DYING;
              cnt_reg          <= RESPAWN_C;
              ship_visible_reg <= 1'b0;
            end else begin
              lives_reg        <= 8'd0;
              state_reg        <= GAME_OVER;
              ship_visible_reg <= 1'b0;
              game_over_reg    <= 1'b1;
            end
          end else if (extra_life) begin
            lives_reg <= lives_inc;
          end
        end
        DYING: begin
          if (extra_life)
            lives_reg <= lives_inc;
          if (frame_tick) begin
            if (cnt_reg == CNT_W'(1)) begin
              state_reg        <= INVULN;
              cnt_reg          <= INVULN_C;
              respawn_reg      <= 1'b1;
              ship_visible_reg <= 1'b1;
              invulnerable_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
        end
        INVULN: begin
          if (extra_life)
            lives_reg <= lives_inc;
          if (frame_tick) begin
            if (cnt_reg == CNT_W'(1)) begin
              state_reg        <= PLAYING;
              invulnerable_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
        end
        GAME_OVER: begin
          if (start_game) begin
            state_reg        <= PLAYING;
            lives_reg        <= START_L;
            ship_visible_reg <= 1'b1;
            game_over_reg    <= 1'b0;
          end
        end
        default: begin
          state_reg        <= IDLE;
          lives_reg        <= 8'd0;
          cnt_reg          <= '0;
          ship_visible_reg <= 1'b0;
          invulnerable_reg <= 1'b0;
          game_over_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign lives        = lives_reg;
  assign ship_visible = ship_visible_reg;
  assign invulnerable = invulnerable_reg;
  assign respawn      = respawn_reg;
  assign game_over    = game_over_reg;
  assign state        = state_reg;

endmodule

// File: tb/tb_lives_manager.sv
// Directed bench for lives_manager: start, hit/respawn timing, saturation, combined hit+award,
// game over and reset abort, with hand-computed expectations.
module tb_lives_manager;

  logic       clk = 1'b0;
  logic       reset, frame_tick, start_game, hit, extra_life;
  logic [7:0] lives;
  logic       ship_visible, invulnerable, respawn, game_over;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  lives_manager dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_game(start_game),
    .hit(hit), .extra_life(extra_life), .lives(lives), .ship_visible(ship_visible),
    .invulnerable(invulnerable), .respawn(respawn), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
    end
  endtask

  task automatic pulse_hit(input logic with_extra);
    hit = 1'b1; extra_life = with_extra; cycle(); hit = 1'b0; extra_life = 1'b0;
  endtask

  task automatic restart();
    reset = 1'b1; cycle(); reset = 1'b0;
    start_game = 1'b1; cycle(); start_game = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_tick = 1'b0; start_game = 1'b0; hit = 1'b0; extra_life = 1'b0;
    cycle(); cycle(); reset = 1'b0;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (lives !== 8'd0) begin failures++; $display("FAIL reset_lives got=%0d exp=0", lives); end
    checks++; if ({ship_visible, invulnerable, respawn, game_over} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {ship_visible, invulnerable, respawn, game_over}); end
    $display("test_reset done");
  endtask

  task automatic test_start();
    pulse_hit(1'b1);
    checks++; if (state !== 3'd0 || lives !== 8'd0) begin
      failures++; $display("FAIL idle_ignore got state=%0d lives=%0d exp state=0 lives=0", state, lives); end
    start_game = 1'b1; cycle(); start_game = 1'b0;
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", state); end
    checks++; if (lives !== 8'd3) begin failures++; $display("FAIL start_lives got=%0d exp=3", lives); end
    checks++; if (ship_visible !== 1'b1) begin failures++; $display("FAIL start_visible got=%b exp=1", ship_visible); end
    $display("test_start done");
  endtask

  task automatic test_hit_respawn();
    int rsp;
    rsp = 0;
    // frame_tick coincides with the entry cycle and must not count
    frame_tick = 1'b1; pulse_hit(1'b0); frame_tick = 1'b0;
    checks++; if (state !== 3'd2 || lives !== 8'd2 || ship_visible !== 1'b0) begin
      failures++; $display("FAIL hit_dying got state=%0d lives=%0d vis=%b exp 2/2/0", state, lives, ship_visible); end
    pulse_hit(1'b0);
    checks++; if (lives !== 8'd2 || state !== 3'd2) begin
      failures++; $display("FAIL hit_in_dying got lives=%0d state=%0d exp 2/2", lives, state); end
    for (int i = 0; i < 59; i++) begin ticks(1); rsp += int'(respawn); end
    checks++; if (state !== 3'd2 || rsp != 0) begin
      failures++; $display("FAIL tick59 got state=%0d respawns=%0d exp 2/0", state, rsp); end
    ticks(1); rsp += int'(respawn);
    checks++; if (respawn !== 1'b1 || state !== 3'd3 || invulnerable !== 1'b1 || ship_visible !== 1'b1) begin
      failures++; $display("FAIL tick60 got rsp=%b state=%0d inv=%b vis=%b exp 1/3/1/1", respawn, state, invulnerable, ship_visible); end
    cycle(); rsp += int'(respawn);
    pulse_hit(1'b0); rsp += int'(respawn);
    checks++; if (lives !== 8'd2 || state !== 3'd3) begin
      failures++; $display("FAIL hit_in_invuln got lives=%0d state=%0d exp 2/3", lives, state); end
    for (int i = 0; i < 119; i++) begin ticks(1); rsp += int'(respawn); end
    checks++; if (state !== 3'd3 || invulnerable !== 1'b1) begin
      failures++; $display("FAIL inv119 got state=%0d inv=%b exp 3/1", state, invulnerable); end
    ticks(1); rsp += int'(respawn);
    checks++; if (state !== 3'd1 || invulnerable !== 1'b0 || ship_visible !== 1'b1) begin
      failures++; $display("FAIL inv120 got state=%0d inv=%b vis=%b exp 1/0/1", state, invulnerable, ship_visible); end
    checks++; if (rsp != 1) begin failures++; $display("FAIL respawn_count got=%0d exp=1", rsp); end
    $display("test_hit_respawn done");
  endtask

  task automatic test_extra_life();
    restart();
    for (int i = 0; i < 7; i++) begin extra_life = 1'b1; cycle(); extra_life = 1'b0; end
    checks++; if (lives !== 8'd8) begin failures++; $display("FAIL extra_sat got=%0d exp=8", lives); end
    extra_life = 1'b1; cycle(); extra_life = 1'b0;
    checks++; if (lives !== 8'd8 || state !== 3'd1) begin
      failures++; $display("FAIL extra_over got lives=%0d state=%0d exp 8/1", lives, state); end
    start_game = 1'b1; cycle(); start_game = 1'b0;
    checks++; if (lives !== 8'd8 || state !== 3'd1) begin
      failures++; $display("FAIL start_in_play got lives=%0d state=%0d exp 8/1", lives, state); end
    $display("test_extra_life done");
  endtask

  task automatic test_hit_and_extra();
    restart();
    pulse_hit(1'b1);
    checks++; if (lives !== 8'd3 || state !== 3'd2) begin
      failures++; $display("FAIL hx_3 got lives=%0d state=%0d exp 3/2", lives, state); end
    extra_life = 1'b1; cycle(); extra_life = 1'b0;
    checks++; if (lives !== 8'd4) begin failures++; $display("FAIL extra_in_dying got=%0d exp=4", lives); end
    restart();
    for (int i = 0; i < 5; i++) begin extra_life = 1'b1; cycle(); extra_life = 1'b0; end
    pulse_hit(1'b1);
    checks++; if (lives !== 8'd7 || state !== 3'd2) begin
      failures++; $display("FAIL hx_8 got lives=%0d state=%0d exp 7/2", lives, state); end
    restart();
    pulse_hit(1'b0); ticks(180);
    pulse_hit(1'b0); ticks(180);
    checks++; if (lives !== 8'd1 || state !== 3'd1) begin
      failures++; $display("FAIL to_one got lives=%0d state=%0d exp 1/1", lives, state); end
    pulse_hit(1'b1);
    checks++; if (lives !== 8'd1 || state !== 3'd2 || game_over !== 1'b0) begin
      failures++; $display("FAIL hx_1 got lives=%0d state=%0d go=%b exp 1/2/0", lives, state, game_over); end
    ticks(180);
    $display("test_hit_and_extra done");
  endtask

  task automatic test_game_over();
    pulse_hit(1'b0);
    checks++; if (lives !== 8'd0 || state !== 3'd4 || game_over !== 1'b1 || ship_visible !== 1'b0) begin
      failures++; $display("FAIL game_over got lives=%0d state=%0d go=%b vis=%b exp 0/4/1/0", lives, state, game_over, ship_visible); end
    extra_life = 1'b1; cycle(); extra_life = 1'b0;
    checks++; if (lives !== 8'd0 || state !== 3'd4) begin
      failures++; $display("FAIL go_extra got lives=%0d state=%0d exp 0/4", lives, state); end
    start_game = 1'b1; cycle(); start_game = 1'b0;
    checks++; if (lives !== 8'd3 || state !== 3'd1 || game_over !== 1'b0) begin
      failures++; $display("FAIL go_restart got lives=%0d state=%0d go=%b exp 3/1/0", lives, state, game_over); end
    $display("test_game_over done");
  endtask

  task automatic test_reset_mid_invuln();
    pulse_hit(1'b0); ticks(60); ticks(10);
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL pre_abort got=%0d exp=3", state); end
    reset = 1'b1; start_game = 1'b1; extra_life = 1'b1; frame_tick = 1'b1; cycle();
    reset = 1'b0; start_game = 1'b0; extra_life = 1'b0; frame_tick = 1'b0;
    checks++; if (state !== 3'd0 || lives !== 8'd0 || invulnerable !== 1'b0 || ship_visible !== 1'b0) begin
      failures++; $display("FAIL abort got state=%0d lives=%0d inv=%b vis=%b exp 0/0/0/0", state, lives, invulnerable, ship_visible); end
    $display("test_reset_mid_invuln done");
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit_respawn();
    test_extra_life();
    test_hit_and_extra();
    test_game_over();
    test_reset_mid_invuln();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lives_manager.md
Name: lives_manager

Overview:
- Sequences the player's life count for the Defender game: game start, ship hits, death/respawn delay, post-respawn invulnerability, extra-life awards and game over.
- Drives the 8-bit lives value consumed by the lives display decoder, plus status flags used by the ship renderer and collision logic.
- All timing is in frames, qualified by a one-cycle frame tick from the video timing block.

Parameters:
- START_LIVES, 3, lives loaded on game start (1..MAX_LIVES)
- MAX_LIVES, 8, saturation ceiling for extra-life awards (must be ≤ 255)
- RESPAWN_FRAMES, 60, frames spent in DYING before the ship reappears (≥ 1)
- INVULN_FRAMES, 120, frames of invulnerability after respawn (≥ 1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- start_game  in  1  level or pulse; requests a new game
- hit  in  1  one-cycle pulse: ship collided with an enemy or shot
- extra_life  in  1  one-cycle pulse: score threshold crossed
- lives  out  8  current life count, unsigned
- ship_visible  out  1  ship is drawn and collidable
- invulnerable  out  1  ship is in the post-respawn protection window
- respawn  out  1  one-cycle pulse on the DYING→INVULN transition
- game_over  out  1  high while in GAME_OVER
- state  out  3  encoded FSM state for debug: IDLE=0, PLAYING=1, DYING=2, INVULN=3, GAME_OVER=4

Behaviour:
- Reset, checked every clk edge with highest priority:
  - state=IDLE, lives=0, frame counter=0.
  - ship_visible=0, invulnerable=0, respawn=0, game_over=0.
  - Reset overrides all inputs in the same cycle and aborts any state, including mid-countdown.
- All outputs are registered. Outputs reflect the new state one cycle after the causing input.
- Frame counter:
  - Width is ceil(log2(max(RESPAWN_FRAMES, INVULN_FRAMES) + 1)).
  - Loaded when entering DYING or INVULN.
  - Decrements only on frame_tick. A frame_tick in the entry cycle is not counted.
  - Leaves the state when the counter is 1 and frame_tick=1.
- IDLE: on start_game=1 → PLAYING, lives=START_LIVES. hit and extra_life are ignored.
- PLAYING: ship_visible=1. Priority is reset > hit > extra_life.
  - hit with lives>1: lives=lives-1, → DYING, counter=RESPAWN_FRAMES.
  - hit with lives==1: lives=0, → GAME_OVER.
  - hit and extra_life in the same cycle: net lives unchanged (unless lives==MAX_LIVES, where the result is MAX_LIVES-1), → DYING. GAME_OVER is never entered in this case.
  - extra_life alone: lives=min(lives+1, MAX_LIVES), stay in PLAYING.
- DYING: ship_visible=0.
  - hit is ignored.
  - extra_life increments lives, saturating at MAX_LIVES.
  - On expiry: → INVULN, counter=INVULN_FRAMES, respawn=1 for that one cycle.
- INVULN: ship_visible=1, invulnerable=1.
  - hit is ignored.
  - extra_life increments lives, saturating.
  - On expiry → PLAYING.
- GAME_OVER: game_over=1, lives=0, ship_visible=0.
  - extra_life and hit are ignored.
  - start_game=1 → PLAYING, lives=START_LIVES, game_over cleared next cycle.
- start_game in PLAYING, DYING or INVULN is ignored (no mid-game restart).
- lives never underflows below 0 and never exceeds MAX_LIVES.
- No illegal state persists: an unused encoding returns to IDLE on the next clk.

Test Plan:
- Reset, then start_game pulse → lives=3, state=PLAYING, ship_visible=1. Asserting reset mid-INVULN → IDLE and lives=0 on the next edge.
- In PLAYING with lives=3, pulse hit → lives=2, state=DYING, ship_visible=0. Then 60 frame_ticks → respawn pulses exactly once, invulnerable=1 for 120 ticks, then state=PLAYING.
- Hits while in DYING and in INVULN → lives unchanged at 2. From lives=1 in PLAYING, hit → lives=0, game_over=1. Then start_game → lives=3, PLAYING.
- extra_life ×7 from lives=3 → lives saturates at 8. A further extra_life → still 8.
- hit and extra_life in the same cycle: lives=3 → stays 3, state=DYING. Lives=8 → 7, DYING. Lives=1 → stays 1, DYING, game_over=0.
- frame_tick in the cycle DYING is entered is not counted → with RESPAWN_FRAMES=60, respawn fires on the 60th tick after entry.
